// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and state encodings for the registered ALU (alu_seq)
// and its iterative multiplier.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h2;
    localparam logic [3:0] OP_SHR = 4'h3;
    localparam logic [3:0] OP_NOT = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;
    localparam logic [3:0] OP_SRA = 4'h9;
    localparam logic [3:0] OP_ROL = 4'hA;
    localparam logic [3:0] OP_ROR = 4'hB;
    localparam logic [3:0] OP_CMP = 4'hC;

    localparam int FL_Z = 0;
    localparam int FL_C = 1;
    localparam int FL_N = 2;
    localparam int FL_V = 3;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;

    // Field order matches the flag bus: [3]V [2]N [1]C [0]Z.
    typedef struct packed {
        logic v;
        logic n;
        logic c;
        logic z;
    } alu_flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH clocks after start,
// then a one-clock done pulse with the 2*WIDTH product held on prod_o.
module alu_mul_iter #(
    parameter int WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [WIDTH-1:0]     a_i,
    input  logic [WIDTH-1:0]     b_i,
    output logic                 done_o,
    output logic [2*WIDTH-1:0]   prod_o
);
    import alu_pkg::*;

    localparam logic [WIDTH-1:0] CNT_LAST = WIDTH'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, mcand_q;
    logic [WIDTH-1:0]   mplier_q, cnt_q;
    logic               run_q, done_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start_i && !run_q) begin
                acc_q    <= '0;
                mcand_q  <= {{WIDTH{1'b0}}, a_i};
                mplier_q <= b_i;
                cnt_q    <= '0;
                run_q    <= 1'b1;
            end else if (run_q) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    run_q  <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign done_o = done_q;
    assign prod_o = acc_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU: operands latched on an accepted start, single-cycle ops resolved one clock
// later, MUL handed to the iterative multiplier; results and flags held until the next done.
module alu_seq #(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             iClk,
    input  logic             iRst_n,
    input  logic             iALU_start,
    input  logic [3:0]       uc_iALU,
    input  logic             math_hab,
    input  logic [WIDTH-1:0] rd_iRX,
    input  logic [WIDTH-1:0] rd_iRY,
    output logic             oALU_busy,
    output logic             oALU_done,
    output logic [WIDTH-1:0] oALU_rd,
    output logic [WIDTH-1:0] oALU_rd_hi,
    output logic [3:0]       oALU_flags
);
    import alu_pkg::*;

    localparam int               MSB   = WIDTH - 1;
    localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

    logic [1:0]         state_q, state_d;
    logic [3:0]         op_q;
    logic               hab_q;
    logic [WIDTH-1:0]   x_q, y_q;
    logic [WIDTH-1:0]   rd_q, rd_d, hi_q, hi_d;
    alu_flags_t         flags_q, flags_d;
    logic               done_q, done_d;

    logic               busy, accept, is_mul, mul_done;
    logic [2*WIDTH-1:0] prod;

    assign busy   = (state_q == ST_MUL);
    assign accept = iALU_start && !busy;
    assign is_mul = math_hab && (uc_iALU == OP_MUL) && (MUL_EN != 0);

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk_i   (iClk),
        .rst_ni  (iRst_n),
        .start_i (accept && is_mul),
        .a_i     (rd_iRX),
        .b_i     (rd_iRY),
        .done_o  (mul_done),
        .prod_o  (prod)
    );

    // Shifts carry one guard bit so the last bit shifted out lands in a fixed position.
    logic [WIDTH:0]        sum, diff, shl_ext, shr_ext;
    logic signed [WIDTH:0] sra_ext;
    logic [WIDTH-1:0]      rot_amt;

    assign sum     = {1'b0, y_q} + {1'b0, x_q};
    assign diff    = {1'b0, y_q} - {1'b0, x_q};
    assign shl_ext = {1'b0, y_q} << x_q;
    assign shr_ext = {y_q, 1'b0} >> x_q;
    assign sra_ext = $signed({y_q, 1'b0}) >>> x_q;
    assign rot_amt = x_q % W_VAL;

    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_wr;

    always_comb begin
        res    = y_q;
        res_c  = 1'b0;
        res_v  = 1'b0;
        res_wr = 1'b1;
        if (hab_q) begin
            unique case (op_q)
                OP_ADD: begin
                    res   = sum[MSB:0];
                    res_c = sum[WIDTH];
                    res_v = (y_q[MSB] == x_q[MSB]) && (sum[MSB] != y_q[MSB]);
                end
                OP_SUB, OP_CMP: begin
                    res    = diff[MSB:0];
                    res_c  = diff[WIDTH];
                    res_v  = (y_q[MSB] != x_q[MSB]) && (diff[MSB] != y_q[MSB]);
                    res_wr = (op_q != OP_CMP);
                end
                OP_SHL: begin
                    res   = shl_ext[MSB:0];
                    res_c = shl_ext[WIDTH];
                end
                OP_SHR: begin
                    res   = shr_ext[WIDTH:1];
                    res_c = shr_ext[0];
                end
                OP_SRA: begin
                    res   = sra_ext[WIDTH:1];
                    res_c = (x_q > W_VAL) ? 1'b0 : sra_ext[0];
                end
                OP_NOT: res = ~x_q;
                OP_AND: res = y_q & x_q;
                OP_OR:  res = y_q | x_q;
                OP_XOR: res = y_q ^ x_q;
                OP_ROL: res = (y_q << rot_amt) | (y_q >> (W_VAL - rot_amt));
                OP_ROR: res = (y_q >> rot_amt) | (y_q << (W_VAL - rot_amt));
                default: res = y_q;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        hi_d    = hi_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        if (state_q == ST_EXEC) begin
            done_d    = 1'b1;
            state_d   = ST_IDLE;
            flags_d.z = (res == '0);
            flags_d.n = res[MSB];
            flags_d.c = res_c;
            flags_d.v = res_v;
            if (res_wr) begin
                rd_d = res;
                hi_d = '0;
            end
        end else if (state_q == ST_MUL && mul_done) begin
            done_d    = 1'b1;
            state_d   = ST_IDLE;
            rd_d      = prod[MSB:0];
            hi_d      = prod[2*WIDTH-1:WIDTH];
            flags_d.z = (prod == '0);
            flags_d.n = prod[2*WIDTH-1];
            flags_d.c = (prod[2*WIDTH-1:WIDTH] != '0);
            flags_d.v = 1'b0;
        end
        // A start in EXEC is legal: the finishing result retires while the new op is latched.
        if (accept) state_d = is_mul ? ST_MUL : ST_EXEC;
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            hab_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            rd_q    <= '0;
            hi_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            hi_q    <= hi_d;
            flags_q <= flags_d;
            done_q  <= done_d;
            if (accept) begin
                op_q  <= uc_iALU;
                hab_q <= math_hab;
                x_q   <= rd_iRX;
                y_q   <= rd_iRY;
            end
        end
    end

    assign oALU_busy  = busy;
    assign oALU_done  = done_q;
    assign oALU_rd    = rd_q;
    assign oALU_rd_hi = hi_q;
    assign oALU_flags = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed checks for alu_seq (WIDTH=8): a vector table of ops with hand-computed results,
// plus sequences for MUL busy/ignored start, CMP hold and reset in mid-multiply.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   op;
    logic         hab;
    logic [W-1:0] rx, ry;
    logic         busy, done;
    logic [W-1:0] rd, rd_hi;
    logic [3:0]   flags;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W), .MUL_EN(1)) dut (
        .iClk       (clk),
        .iRst_n     (rst_n),
        .iALU_start (start),
        .uc_iALU    (op),
        .math_hab   (hab),
        .rd_iRX     (rx),
        .rd_iRY     (ry),
        .oALU_busy  (busy),
        .oALU_done  (done),
        .oALU_rd    (rd),
        .oALU_rd_hi (rd_hi),
        .oALU_flags (flags)
    );

    typedef struct {
        logic [3:0]   op;
        logic         hab;
        logic [W-1:0] y;
        logic [W-1:0] x;
        logic [W-1:0] rd;
        logic [W-1:0] hi;
        logic [3:0]   fl;   // {V,N,C,Z}
        int           lat;
    } vec_t;

    localparam int NV = 24;
    vec_t tv [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one op and wait (bounded) for done; optionally pulse a stray ADD start at cycle inj.
    task automatic run_op(input logic [3:0] o, input logic h, input logic [W-1:0] y,
                          input logic [W-1:0] x, input int inj, output int lat, output int bcnt);
        @(negedge clk);
        op = o; hab = h; ry = y; rx = x; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            if (lat == inj) begin
                start = 1'b1; op = OP_ADD; hab = 1'b1; ry = 8'h01; rx = 8'h01;
            end
            @(negedge clk);
            start = 1'b0;
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, seen;

        tv[0]  = '{OP_ADD, 1'b1, 8'h7F, 8'h01, 8'h80, 8'h00, 4'b1100, 1};
        tv[1]  = '{OP_SUB, 1'b1, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0110, 1};
        tv[2]  = '{OP_CMP, 1'b1, 8'h00, 8'h01, 8'hFF, 8'h00, 4'b0110, 1};
        tv[3]  = '{OP_SRA, 1'b1, 8'h80, 8'h09, 8'hFF, 8'h00, 4'b0100, 1};
        tv[4]  = '{OP_SHL, 1'b1, 8'h81, 8'h01, 8'h02, 8'h00, 4'b0010, 1};
        tv[5]  = '{OP_ROR, 1'b1, 8'h01, 8'h09, 8'h80, 8'h00, 4'b0100, 1};
        tv[6]  = '{OP_ADD, 1'b0, 8'h00, 8'h55, 8'h00, 8'h00, 4'b0001, 1};
        tv[7]  = '{OP_SHR, 1'b1, 8'h81, 8'h08, 8'h00, 8'h00, 4'b0011, 1};
        tv[8]  = '{OP_SHL, 1'b1, 8'h01, 8'h08, 8'h00, 8'h00, 4'b0011, 1};
        tv[9]  = '{OP_SHR, 1'b1, 8'hFF, 8'h09, 8'h00, 8'h00, 4'b0001, 1};
        tv[10] = '{OP_ADD, 1'b1, 8'hFF, 8'h01, 8'h00, 8'h00, 4'b0011, 1};
        tv[11] = '{OP_SUB, 1'b1, 8'h80, 8'h01, 8'h7F, 8'h00, 4'b1000, 1};
        tv[12] = '{OP_NOT, 1'b1, 8'hAA, 8'h0F, 8'hF0, 8'h00, 4'b0100, 1};
        tv[13] = '{OP_AND, 1'b1, 8'hF0, 8'h3C, 8'h30, 8'h00, 4'b0000, 1};
        tv[14] = '{OP_OR,  1'b1, 8'hF0, 8'h0F, 8'hFF, 8'h00, 4'b0100, 1};
        tv[15] = '{OP_XOR, 1'b1, 8'hAA, 8'hAA, 8'h00, 8'h00, 4'b0001, 1};
        tv[16] = '{OP_ROL, 1'b1, 8'h81, 8'h01, 8'h03, 8'h00, 4'b0000, 1};
        tv[17] = '{OP_SRA, 1'b1, 8'hC2, 8'h02, 8'hF0, 8'h00, 4'b0110, 1};
        tv[18] = '{4'hE,   1'b1, 8'h5A, 8'h00, 8'h5A, 8'h00, 4'b0000, 1};
        tv[19] = '{OP_SHR, 1'b1, 8'h81, 8'h00, 8'h81, 8'h00, 4'b0100, 1};
        tv[20] = '{OP_MUL, 1'b1, 8'h03, 8'h05, 8'h0F, 8'h00, 4'b0000, 9};
        tv[21] = '{OP_ADD, 1'b1, 8'h01, 8'h01, 8'h02, 8'h00, 4'b0000, 1};
        tv[22] = '{OP_SUB, 1'b1, 8'h05, 8'h05, 8'h00, 8'h00, 4'b0001, 1};
        tv[23] = '{OP_MUL, 1'b1, 8'h00, 8'h07, 8'h00, 8'h00, 4'b0001, 9};

        rst_n = 1'b0; start = 1'b0; op = '0; hab = 1'b0; rx = '0; ry = '0;
        #2;
        chk("reset done",  {31'd0, done},  32'd0);
        chk("reset busy",  {31'd0, busy},  32'd0);
        chk("reset rd",    {24'd0, rd},    32'd0);
        chk("reset hi",    {24'd0, rd_hi}, 32'd0);
        chk("reset flags", {28'd0, flags}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            run_op(tv[i].op, tv[i].hab, tv[i].y, tv[i].x, -1, lat, bcnt);
            chk($sformatf("v%0d latency", i), lat, tv[i].lat);
            chk($sformatf("v%0d busy", i), bcnt, (tv[i].lat == 1) ? 0 : tv[i].lat);
            chk($sformatf("v%0d rd", i), {24'd0, rd}, {24'd0, tv[i].rd});
            chk($sformatf("v%0d hi", i), {24'd0, rd_hi}, {24'd0, tv[i].hi});
            chk($sformatf("v%0d flags", i), {28'd0, flags}, {28'd0, tv[i].fl});
            @(negedge clk);
            chk($sformatf("v%0d done pulse", i), {31'd0, done}, 32'd0);
        end

        // MUL 0xFF*0xFF with a stray ADD start during busy that must be dropped.
        run_op(OP_MUL, 1'b1, 8'hFF, 8'hFF, 3, lat, bcnt);
        chk("mul latency", lat, W + 1);
        chk("mul busy",    bcnt, W + 1);
        chk("mul busy end", {31'd0, busy}, 32'd0);
        chk("mul rd",      {24'd0, rd},    32'h01);
        chk("mul hi",      {24'd0, rd_hi}, 32'hFE);
        chk("mul flags",   {28'd0, flags}, 32'b0110);
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mul no extra done", seen, 0);
        chk("mul rd held", {24'd0, rd}, 32'h01);

        // CMP updates flags only; the MUL product stays on rd/hi.
        run_op(OP_CMP, 1'b1, 8'h01, 8'h02, -1, lat, bcnt);
        chk("cmp latency", lat, 1);
        chk("cmp flags",   {28'd0, flags}, 32'b0110);
        chk("cmp rd",      {24'd0, rd},    32'h01);
        chk("cmp hi",      {24'd0, rd_hi}, 32'hFE);

        // Reset in the middle of a multiply.
        @(negedge clk);
        op = OP_MUL; hab = 1'b1; ry = 8'h12; rx = 8'h34; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre-reset busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid reset busy",  {31'd0, busy},  32'd0);
        chk("mid reset done",  {31'd0, done},  32'd0);
        chk("mid reset rd",    {24'd0, rd},    32'd0);
        chk("mid reset hi",    {24'd0, rd_hi}, 32'd0);
        chk("mid reset flags", {28'd0, flags}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("post reset idle", seen, 0);
        run_op(OP_ADD, 1'b1, 8'h02, 8'h03, -1, lat, bcnt);
        chk("post reset latency", lat, 1);
        chk("post reset rd",    {24'd0, rd},    32'h05);
        chk("post reset hi",    {24'd0, rd_hi}, 32'h00);
        chk("post reset flags", {28'd0, flags}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
